// File: rtl/cpu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_sequencer_pkg
//  Purpose  : Shared types and constants for the accumulator CPU sequencer:
//             opcodes, one-hot instruction phases, the datapath strobe bundle.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_sequencer_pkg;

  // 3-bit opcode field of the instruction register; every encoding is legal.
  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcodes_t;

  // One-hot phase encoding; any other pattern is treated as corrupt.
  typedef enum logic [7:0] {
    INST_ADDR  = 8'h01,
    INST_FETCH = 8'h02,
    INST_LOAD  = 8'h04,
    IDLE       = 8'h08,
    OP_ADDR    = 8'h10,
    OP_FETCH   = 8'h20,
    ALU_OP     = 8'h40,
    STORE      = 8'h80
  } state_t;

  // Datapath strobes, sel in the MSB.
  typedef struct packed {
    logic sel;
    logic rd;
    logic ld_ir;
    logic inc_pc;
    logic ld_pc;
    logic ld_ac;
    logic wr;
    logic data_e;
  } ctrl_t;

  localparam int INSTR_CYCLES = 8;

  localparam ctrl_t CTRL_IDLE = '{sel: 1'b1, rd: 1'b0, ld_ir: 1'b0, inc_pc: 1'b0,
                                  ld_pc: 1'b0, ld_ac: 1'b0, wr: 1'b0, data_e: 1'b0};

  // Opcodes that read memory and load the accumulator from the ALU.
  function automatic logic is_aluop(input opcodes_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_sequencer_ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_decode
//  Purpose  : Purely combinational decode of (phase, opcode, zero, halted)
//             into the datapath strobe bundle.
//  Revision : 1.0 - initial release
// ============================================================================
module ctrl_decode
  import cpu_sequencer_pkg::*;
(
  input  state_t   phase,
  input  opcodes_t opcode,
  input  logic     zero,
  input  logic     halted,
  output ctrl_t    ctrl
);

  logic w_alu;
  assign w_alu = is_aluop(opcode);

  // Strobe decode; a halted machine drives nothing.
  always_comb begin
    ctrl = '0;
    if (!halted) begin
      case (phase)
        INST_ADDR: begin
          ctrl.sel = 1'b1;
        end
        INST_FETCH: begin
          ctrl.sel = 1'b1;
          ctrl.rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          ctrl.sel   = 1'b1;
          ctrl.rd    = 1'b1;
          ctrl.ld_ir = 1'b1;
        end
        OP_ADDR: begin
          ctrl.inc_pc = (opcode != HLT);
        end
        OP_FETCH: begin
          ctrl.rd     = w_alu;
          ctrl.inc_pc = (opcode == SKZ) && zero;
        end
        ALU_OP: begin
          ctrl.rd     = w_alu;
          ctrl.ld_ac  = w_alu;
          ctrl.ld_pc  = (opcode == JMP);
          ctrl.data_e = (opcode == STO);
        end
        STORE: begin
          ctrl.rd     = w_alu;
          ctrl.ld_ac  = w_alu;
          ctrl.ld_pc  = (opcode == JMP);
          ctrl.inc_pc = (opcode == JMP);
          ctrl.wr     = (opcode == STO);
          ctrl.data_e = (opcode == STO);
        end
        default: begin
          ctrl = '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_sequencer
//  Purpose  : Eight-phase control FSM of the accumulator CPU. Holds the phase
//             register, the sticky halt flag and the retired-instruction
//             counter; strobes come from ctrl_decode.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  opcodes_t         opcode,
  input  logic             zero,
  output state_t           phase,
  output logic             sel,
  output logic             rd,
  output logic             ld_ir,
  output logic             inc_pc,
  output logic             ld_pc,
  output logic             ld_ac,
  output logic             wr,
  output logic             data_e,
  output logic             halt,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t           r_phase;
  state_t           w_phase_next;
  logic             r_halted;
  logic             w_halted_next;
  logic [CNT_W-1:0] r_cnt;
  ctrl_t            w_ctrl;

  // State register, halt flag and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase  <= INST_ADDR;
      r_halted <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_phase  <= w_phase_next;
      r_halted <= w_halted_next;
      if (r_phase == STORE && !r_halted) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Next phase: fixed ring, except HLT parks the machine in OP_ADDR.
  always_comb begin
    w_phase_next  = INST_ADDR;
    w_halted_next = r_halted;
    if (r_halted) begin
      w_phase_next = r_phase;
    end else begin
      case (r_phase)
        INST_ADDR:  w_phase_next = INST_FETCH;
        INST_FETCH: w_phase_next = INST_LOAD;
        INST_LOAD:  w_phase_next = IDLE;
        IDLE:       w_phase_next = OP_ADDR;
        OP_ADDR: begin
          if (opcode == HLT) begin
            w_phase_next  = OP_ADDR;
            w_halted_next = 1'b1;
          end else begin
            w_phase_next = OP_FETCH;
          end
        end
        OP_FETCH:   w_phase_next = ALU_OP;
        ALU_OP:     w_phase_next = STORE;
        STORE:      w_phase_next = INST_ADDR;
        default:    w_phase_next = INST_ADDR;
      endcase
    end
  end

  ctrl_decode u_ctrl_decode (
    .phase  (r_phase),
    .opcode (opcode),
    .zero   (zero),
    .halted (r_halted),
    .ctrl   (w_ctrl)
  );

  assign {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e} = w_ctrl;
  assign phase     = r_phase;
  assign halt      = r_halted;
  assign instr_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_sequencer
//  Purpose  : Self-checking bench for cpu_sequencer (16-bit and 4-bit counter
//             instances driven in lock-step).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  opcodes_t opcode = LDA;
  logic     zero = 1'b0;

  state_t      phase, phase4;
  logic        sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic        sel4, rd4, ld_ir4, inc_pc4, ld_pc4, ld_ac4, wr4, data_e4, halt4;
  logic [15:0] cnt;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  cpu_sequencer #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .phase(phase),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
    .ld_ac(ld_ac), .wr(wr), .data_e(data_e), .halt(halt), .instr_cnt(cnt)
  );

  cpu_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .phase(phase4),
    .sel(sel4), .rd(rd4), .ld_ir(ld_ir4), .inc_pc(inc_pc4), .ld_pc(ld_pc4),
    .ld_ac(ld_ac4), .wr(wr4), .data_e(data_e4), .halt(halt4), .instr_cnt(cnt4)
  );

  typedef struct {
    state_t      ph;
    logic [7:0]  strobes;
    logic        hlt;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    opcodes_t op;
    logic     z;
  } vec_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] model_cnt = 16'd0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic state_t phase_of(input int k);
    case (k)
      0: return INST_ADDR;
      1: return INST_FETCH;
      2: return INST_LOAD;
      3: return IDLE;
      4: return OP_ADDR;
      5: return OP_FETCH;
      6: return ALU_OP;
      default: return STORE;
    endcase
  endfunction

  // Expected strobes {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e} in cycle k.
  function automatic logic [7:0] exp_strobes(input opcodes_t op, input logic z, input int k);
    logic alu;
    logic jmp;
    logic sto;
    alu = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    jmp = (op == JMP);
    sto = (op == STO);
    case (k)
      0: return 8'b1000_0000;
      1: return 8'b1100_0000;
      2: return 8'b1110_0000;
      3: return 8'b1110_0000;
      4: return (op == HLT) ? 8'b0000_0000 : 8'b0001_0000;
      5: return {1'b0, alu, 1'b0, (op == SKZ) && z, 4'b0000};
      6: return {1'b0, alu, 2'b00, jmp, alu, 1'b0, sto};
      default: return {1'b0, alu, 1'b0, jmp, jmp, alu, sto, sto};
    endcase
  endfunction

  task automatic check_cycle(input exp_t e, input string tag);
    check({tag, " phase"},     32'(phase),  32'(e.ph));
    check({tag, " strobes"},   32'({sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e}), 32'(e.strobes));
    check({tag, " halt"},      32'(halt),   32'(e.hlt));
    check({tag, " instr_cnt"}, 32'(cnt),    32'(e.cnt));
    check({tag, " phase4"},    32'(phase4), 32'(e.ph));
    check({tag, " strobes4"},  32'({sel4, rd4, ld_ir4, inc_pc4, ld_pc4, ld_ac4, wr4, data_e4}), 32'(e.strobes));
    check({tag, " halt4"},     32'(halt4),  32'(e.hlt));
    check({tag, " cnt4"},      32'(cnt4),   32'(e.cnt[3:0]));
  endtask

  // Queue the expected phases of (a prefix of) one instruction, then step it.
  task automatic run_instr(input opcodes_t op, input logic z, input int n, input bit last_tick);
    exp_t e;
    opcode = op;
    zero   = z;
    for (int k = 0; k < n; k++) begin
      sb.push_back('{phase_of(k), exp_strobes(op, z, k), 1'b0, model_cnt});
    end
    for (int k = 0; k < n; k++) begin
      e = sb.pop_front();
      check_cycle(e, $sformatf("%s z%0d k%0d", op.name(), z, k));
      if (k < n - 1 || last_tick) tick();
    end
    if (n == INSTR_CYCLES && last_tick) model_cnt++;
  endtask

  task automatic check_reset_state(input string tag);
    check_cycle('{INST_ADDR, 8'b1000_0000, 1'b0, 16'd0}, tag);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{LDA, 1'b0};
    vecs[1] = '{SKZ, 1'b1};
    vecs[2] = '{SKZ, 1'b0};
    vecs[3] = '{JMP, 1'b0};
    vecs[4] = '{STO, 1'b1};
    vecs[5] = '{ADD, 1'b0};
    vecs[6] = '{AND, 1'b1};
    vecs[7] = '{XOR, 1'b0};
    vecs[8] = '{LDA, 1'b1};

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check_reset_state("reset");
    rst = 1'b0;

    // Table-driven instructions, full 8-cycle sequences
    for (int i = 0; i < 9; i++) begin
      run_instr(vecs[i].op, vecs[i].z, INSTR_CYCLES, 1'b1);
    end

    // HLT: decode in OP_ADDR, then frozen for 20 cycles
    run_instr(HLT, 1'b0, 5, 1'b1);
    for (int c = 0; c < 20; c++) begin
      check_cycle('{OP_ADDR, 8'h00, 1'b1, model_cnt}, $sformatf("halted c%0d", c));
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_cnt = 16'd0;
    check_reset_state("reset after halt");

    // Reset during ALU_OP of an STO: no write, instruction not counted
    run_instr(STO, 1'b0, 7, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("reset mid STO");
    check("reset mid STO wr", 32'(wr), 32'd0);

    // Counter wrap on the 4-bit instance
    for (int i = 0; i < 16; i++) begin
      run_instr(ADD, 1'b0, INSTR_CYCLES, 1'b1);
      if (i == 14) check("cnt4 before wrap", 32'(cnt4), 32'd15);
    end
    check("cnt4 after wrap", 32'(cnt4), 32'd0);
    check("cnt16 after 16 ADD", 32'(cnt), 32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
